// File: rtl/mult_div_unit_if.sv
// Execute-stage handshake between the control path and the HI/LO multiply/divide engine.
// The master drives operation requests and MF reads; the slave returns HI/LO and status.
interface mult_div_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             op_div;
   logic             is_signed;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             mf_req;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic             stall;

   modport master (
      output start, op_div, is_signed, src_a, src_b, mf_req,
      input  hi, lo, busy, done, div_by_zero, stall
   );

   modport slave (
      input  start, op_div, is_signed, src_a, src_b, mf_req,
      output hi, lo, busy, done, div_by_zero, stall
   );
endinterface

// File: rtl/mult_div_unit.sv
// Bit-serial multiply/divide engine owning HI/LO. Every operation takes WIDTH+1 edges
// from the start edge; MFHI/MFLO are stalled until the new HI/LO are visible.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   mult_div_unit_if.slave bus
);
   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int unsigned AW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t           state, state_nxt;
   logic [AW-1:0]    acc, acc_nxt;
   logic [WIDTH-1:0] opb, opb_nxt;
   logic [WIDTH-1:0] raw_a, raw_a_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             is_div, is_div_nxt;
   logic             neg_res, neg_res_nxt;
   logic             neg_rem, neg_rem_nxt;
   logic             zero_div, zero_div_nxt;
   logic [WIDTH-1:0] hi_q, hi_nxt;
   logic [WIDTH-1:0] lo_q, lo_nxt;
   logic             busy_q, busy_nxt;
   logic             done_q, done_nxt;
   logic             dbz_q, dbz_nxt;

   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   add_sum, div_shift, div_trial;
   logic [AW-1:0]    prod;
   logic [WIDTH-1:0] quo, rem;

   // Operand magnitudes, per-iteration arithmetic and final sign correction
   always_comb begin
      mag_a     = (bus.is_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
      mag_b     = (bus.is_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
      add_sum   = {1'b0, acc[AW-1:WIDTH]} + {1'b0, (acc[0] ? opb : WIDTH'(0))};
      div_shift = {acc[AW-1:WIDTH], acc[WIDTH-1]};
      div_trial = div_shift - {1'b0, opb};
      prod      = neg_res ? -acc : acc;
      quo       = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem       = neg_rem ? -acc[AW-1:WIDTH] : acc[AW-1:WIDTH];
   end

   always_comb begin
      state_nxt    = state;
      acc_nxt      = acc;
      opb_nxt      = opb;
      raw_a_nxt    = raw_a;
      cnt_nxt      = cnt;
      is_div_nxt   = is_div;
      neg_res_nxt  = neg_res;
      neg_rem_nxt  = neg_rem;
      zero_div_nxt = zero_div;
      hi_nxt       = hi_q;
      lo_nxt       = lo_q;
      busy_nxt     = busy_q;
      done_nxt     = 1'b0;
      dbz_nxt      = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start) begin
               acc_nxt      = {WIDTH'(0), mag_a};
               opb_nxt      = mag_b;
               raw_a_nxt    = bus.src_a;
               is_div_nxt   = bus.op_div;
               neg_res_nxt  = bus.is_signed & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
               neg_rem_nxt  = bus.is_signed & bus.src_a[WIDTH-1];
               zero_div_nxt = bus.op_div & (bus.src_b == WIDTH'(0));
               cnt_nxt      = CW'(WIDTH - 1);
               busy_nxt     = 1'b1;
               state_nxt    = CALC;
            end
         end
         CALC: begin
            // Multiply shifts the accumulator right; divide shifts remainder:quotient left
            if (is_div) begin
               if (div_trial[WIDTH])
                  acc_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
               else
                  acc_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
               acc_nxt = {add_sum, acc[WIDTH-1:1]};
            end
            if (cnt == CW'(0))
               state_nxt = FIX;
            else
               cnt_nxt = cnt - CW'(1);
         end
         FIX: begin
            if (is_div) begin
               if (zero_div) begin
                  lo_nxt  = '1;
                  hi_nxt  = raw_a;
                  dbz_nxt = 1'b1;
               end else begin
                  lo_nxt = quo;
                  hi_nxt = rem;
               end
            end else begin
               hi_nxt = prod[AW-1:WIDTH];
               lo_nxt = prod[WIDTH-1:0];
            end
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         acc      <= '0;
         opb      <= '0;
         raw_a    <= '0;
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         zero_div <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         acc      <= acc_nxt;
         opb      <= opb_nxt;
         raw_a    <= raw_a_nxt;
         cnt      <= cnt_nxt;
         is_div   <= is_div_nxt;
         neg_res  <= neg_res_nxt;
         neg_rem  <= neg_rem_nxt;
         zero_div <= zero_div_nxt;
         hi_q     <= hi_nxt;
         lo_q     <= lo_nxt;
         busy_q   <= busy_nxt;
         done_q   <= done_nxt;
         dbz_q    <= dbz_nxt;
      end
   end

   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.stall       = bus.mf_req & (busy_q | bus.start);
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: signed/unsigned mul/div, divide by zero,
// MF stall hazard with an ignored second start, and asynchronous reset mid-operation.
module tb_mult_div_unit;
   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic reset_n;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mult_div_unit_if #(.WIDTH(W)) bus ();

   mult_div_unit #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_start(input logic op, input logic sgn, input logic [W-1:0] a,
                              input logic [W-1:0] b);
      bus.start     = 1'b1;
      bus.op_div    = op;
      bus.is_signed = sgn;
      bus.src_a     = a;
      bus.src_b     = b;
   endtask

   // Bounded wait for done; returns edges counted since the start edge
   task automatic wait_done(output int lat);
      lat = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         lat++;
         if (bus.done) break;
      end
   endtask

   task automatic run_op(input string tag, input logic op, input logic sgn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                         input logic exp_dbz);
      int lat;
      drive_start(op, sgn, a, b);
      tick();
      bus.start = 1'b0;
      check({tag, "_busy"}, 64'(bus.busy), 64'(1));
      wait_done(lat);
      check({tag, "_lat"}, 64'(lat), 64'(33));
      check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
      check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
      check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
      check({tag, "_busy_done"}, 64'(bus.busy), 64'(0));
      tick();
      check({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
      check({tag, "_dbz_pulse"}, 64'(bus.div_by_zero), 64'(0));
      check({tag, "_hold_lo"}, 64'(bus.lo), 64'(exp_lo));
   endtask

   initial begin
      int lat;
      int stall_cnt;

      reset_n       = 1'b0;
      bus.start     = 1'b0;
      bus.op_div    = 1'b0;
      bus.is_signed = 1'b0;
      bus.src_a     = '0;
      bus.src_b     = '0;
      bus.mf_req    = 1'b0;
      repeat (2) tick();
      check("rst_hi", 64'(bus.hi), 64'(0));
      check("rst_lo", 64'(bus.lo), 64'(0));
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_done", 64'(bus.done), 64'(0));
      check("rst_dbz", 64'(bus.div_by_zero), 64'(0));
      #4 reset_n = 1'b1;
      tick();

      run_op("smul", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run_op("sdiv", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("sdiv_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
      run_op("udiv", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 1'b0);
      run_op("umul", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
      run_op("div0", 1'b1, 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
      run_op("div0_neg", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

      // Hazard: mf_req held from the start cycle, stray start at E+5 must be ignored
      bus.mf_req = 1'b1;
      drive_start(1'b0, 1'b0, 32'd100, 32'd3);
      #1;
      check("hz_stall_start", 64'(bus.stall), 64'(1));
      tick();
      bus.start = 1'b0;
      stall_cnt = 0;
      lat       = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.done) break;
         if (bus.stall) stall_cnt++;
         if (k == 4) drive_start(1'b1, 1'b0, 32'd77, 32'd11);
         if (k == 5) bus.start = 1'b0;
         tick();
         lat++;
      end
      check("hz_lat", 64'(lat), 64'(33));
      check("hz_stall_cnt", 64'(stall_cnt), 64'(33));
      check("hz_stall_done", 64'(bus.stall), 64'(0));
      check("hz_hi", 64'(bus.hi), 64'(0));
      check("hz_lo", 64'(bus.lo), 64'(300));
      bus.mf_req = 1'b0;
      tick();
      check("hz_idle_busy", 64'(bus.busy), 64'(0));

      // Asynchronous reset at E+10 discards the in-flight divide
      drive_start(1'b1, 1'b0, 32'd1000, 32'd7);
      tick();
      bus.start = 1'b0;
      repeat (10) tick();
      reset_n = 1'b0;
      #1;
      check("mrst_hi", 64'(bus.hi), 64'(0));
      check("mrst_lo", 64'(bus.lo), 64'(0));
      check("mrst_busy", 64'(bus.busy), 64'(0));
      check("mrst_done", 64'(bus.done), 64'(0));
      #2 reset_n = 1'b1;
      run_op("post_rst_mul", 1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide engine that owns the HI/LO register pair for MULT/MULTU/DIV/DIVU, and serves MFHI/MFLO reads. It sits beside the ALU in the execute stage. It is started by the control path and raises a stall while a result is pending, so that MFHI/MFLO never read a stale HI/LO. The datapath processes one bit per cycle and uses a fixed latency for every operation.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request a new operation; sampled only when busy=0
op_div  input  1  0 = multiply, 1 = divide (sampled with start)
is_signed  input  1  1 = two's-complement operands, 0 = unsigned (sampled with start)
src_a  input  WIDTH  multiplicand / dividend (sampled with start)
src_b  input  WIDTH  multiplier / divisor (sampled with start)
mf_req  input  1  an MFHI/MFLO instruction wants hi/lo this cycle
hi  output  WIDTH  HI register: product upper half or remainder
lo  output  WIDTH  LO register: product lower half or quotient
busy  output  1  operation in progress
done  output  1  one-cycle pulse in the first cycle new hi/lo are visible
div_by_zero  output  1  one-cycle pulse coincident with done, for a divide with src_b=0
stall  output  1  combinational: mf_req & (busy | start)

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - An in-flight operation is discarded.
  - The first rising edge after reset_n returns high may accept a start.
- States: IDLE, CALC, FIX.
- IDLE:
  - On an edge with start=1, latch op_div and is_signed.
  - Latch |src_a| and |src_b|: absolute value when is_signed=1, raw value otherwise.
  - Latch the result-sign flags.
  - Load iteration counter = WIDTH-1, go to CALC, set busy=1.
- CALC:
  - One iteration per edge, for exactly WIDTH edges. Counter decrements and goes to FIX when it reaches 0.
  - Multiply: shift-add on magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring division on magnitudes (shift remainder left, trial subtract, set quotient bit).
- FIX (one edge):
  - Apply the sign correction and write hi/lo.
  - Set done=1 and busy=0, go to IDLE.
  - done and div_by_zero are registered and last exactly one cycle.
- Latency:
  - start sampled at edge E. busy=1 from E through E+WIDTH+1.
  - hi/lo update and done=1 at edge E+WIDTH+1 (33 edges for WIDTH=32).
  - A new start may be sampled in the same cycle done is high.
- Signed rules:
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ; remainder takes the sign of the dividend.
  - Arithmetic is modulo 2^WIDTH per half. For signed (-2^(WIDTH-1)) / (-1): lo=0x80000000, hi=0.
- Divide by zero:
  - Full latency is still taken.
  - lo = all ones; hi = src_a exactly as sampled (no sign handling).
  - div_by_zero pulses with done.
- start while busy=1: ignored. No state, operand or hi/lo change; the control path must not issue it.
- stall:
  - High whenever mf_req=1 and an operation is pending or being started this cycle.
  - Low in the done cycle, so MFHI/MFLO read the new hi/lo.
- hi/lo hold their value in all states except the FIX edge.

Test Plan:
- Signed multiply: start, op_div=0, is_signed=1, src_a=7, src_b=0xFFFFFFFD (-3) -> at edge E+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses for 1 cycle, busy low afterwards.
- Signed divide: src_a=0xFFFFFFF9 (-7), src_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also src_a=0x80000000, src_b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Unsigned divide: is_signed=0, src_a=0xFFFFFFFF, src_b=0x10 -> lo=0x0FFFFFFF, hi=0xF. Unsigned multiply of 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Divide by zero: src_a=5, src_b=0 -> after 33 edges lo=0xFFFFFFFF, hi=5, div_by_zero and done both high for exactly 1 cycle.
- Hazard:
  - mf_req held high from the start cycle -> stall=1 for 33 cycles, 0 in the done cycle.
  - A second start at E+5 with different operands -> ignored, and the result matches the first operation.
- Reset mid-operation: drive reset_n low at E+10 -> hi=lo=0, busy=0, done=0 immediately (asynchronously). After release, a new multiply 3*4 gives hi=0, lo=12 at its own E'+33.
